// File: rtl/debounce_pkg.sv
// Shared widths and helpers for the push-button debounce/auto-repeat bank.
package debounce_pkg;

  localparam int unsigned DB_CNT_W_DEF    = 6;
  localparam int unsigned RPT_W_DEF       = 25;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  // True when the low w bits of v are all ones (w up to 32).
  function automatic logic all_ones(input logic [31:0] v, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v == mask);
  endfunction

endpackage

// File: rtl/debounce_repeat_bank_if.sv
// Button-bank bus: raw inputs and repeat controls in, conditioned events out.
interface debounce_repeat_bank_if
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned RPT_W  = RPT_W_DEF
);

  logic [NUM_CH-1:0] pb_in;
  logic [NUM_CH-1:0] rpt_en;
  logic [RPT_W-1:0]  rpt_delay;
  logic [RPT_W-1:0]  rpt_period;
  logic [NUM_CH-1:0] pb_state;
  logic [NUM_CH-1:0] pb_down;
  logic [NUM_CH-1:0] pb_up;
  logic [NUM_CH-1:0] pb_rpt;
  logic              pb_any;

  modport master (
    output pb_in, rpt_en, rpt_delay, rpt_period,
    input  pb_state, pb_down, pb_up, pb_rpt, pb_any
  );

  modport slave (
    input  pb_in, rpt_en, rpt_delay, rpt_period,
    output pb_state, pb_down, pb_up, pb_rpt, pb_any
  );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, saturating-window debounce, edge pulses
// and keyboard-style auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CNT_W    = DB_CNT_W_DEF,
  parameter int unsigned RPT_W       = RPT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pb_in,
  input  logic             rpt_en,
  input  logic [RPT_W-1:0] rpt_delay,
  input  logic [RPT_W-1:0] rpt_period,
  output logic             pb_state,
  output logic             pb_down,
  output logic             pb_up,
  output logic             pb_rpt
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0]   sync_q, sync_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0]    rcnt_q, rcnt_d;
  logic [RPT_W-1:0]    target;
  logic                state_q, state_d;
  logic                down_q, down_d;
  logic                up_q, up_d;
  logic                rpt_q, rpt_d;
  logic                first_q, first_d;
  logic                pb_lvl;
  logic                sync_out;

  // Internal level is always 1 = pressed.
  assign pb_lvl   = ACTIVE_LOW ? ~pb_in : pb_in;
  assign sync_out = sync_q[SYNC_N-1];

  always_comb begin
    sync_d = {sync_q[SYNC_N-2:0], pb_lvl};
  end

  // Debounce: count mismatch cycles; accept the new level once the window saturates.
  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    if (sync_out != state_q) begin
      if (all_ones(32'(cnt_q), DB_CNT_W)) begin
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
    down_d = state_d & ~state_q;
    up_d   = state_q & ~state_d;
  end

  // Auto-repeat; >= lets a lowered delay/period fire immediately.
  always_comb begin
    rcnt_d  = '0;
    first_d = 1'b1;
    rpt_d   = 1'b0;
    target  = first_q ? rpt_delay : rpt_period;
    if (down_d) begin
      rcnt_d = RPT_W'(1);
    end else if (state_q && rpt_en) begin
      first_d = first_q;
      if ((target != '0) && (rcnt_q >= target)) begin
        rpt_d   = state_d;
        rcnt_d  = RPT_W'(1);
        first_d = 1'b0;
      end else if (all_ones(32'(rcnt_q), RPT_W)) begin
        rcnt_d = rcnt_q;
      end else begin
        rcnt_d = rcnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      rpt_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      down_q  <= down_d;
      up_q    <= up_d;
      rpt_q   <= rpt_d;
      first_q <= first_d;
    end
  end

  assign pb_state = state_q;
  assign pb_down  = down_q;
  assign pb_up    = up_q;
  assign pb_rpt   = rpt_q;

endmodule

// File: rtl/debounce_repeat_bank.sv
// NUM_CH independent debounce/auto-repeat channels plus an any-pressed flag.
module debounce_repeat_bank
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DB_CNT_W    = DB_CNT_W_DEF,
  parameter int unsigned RPT_W       = RPT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  debounce_repeat_bank_if.slave bus
);

  logic [NUM_CH-1:0] state_v;
  logic [NUM_CH-1:0] down_v;
  logic [NUM_CH-1:0] up_v;
  logic [NUM_CH-1:0] rpt_v;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .DB_CNT_W    (DB_CNT_W),
      .RPT_W       (RPT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .pb_in      (bus.pb_in[g]),
      .rpt_en     (bus.rpt_en[g]),
      .rpt_delay  (bus.rpt_delay),
      .rpt_period (bus.rpt_period),
      .pb_state   (state_v[g]),
      .pb_down    (down_v[g]),
      .pb_up      (up_v[g]),
      .pb_rpt     (rpt_v[g])
    );
  end

  assign bus.pb_state = state_v;
  assign bus.pb_down  = down_v;
  assign bus.pb_up    = up_v;
  assign bus.pb_rpt   = rpt_v;
  assign bus.pb_any   = |state_v;

endmodule

// File: tb/tb_debounce_repeat_bank.sv
// Directed bench for debounce_repeat_bank with a cycle-by-cycle reference model.
module tb_debounce_repeat_bank;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DB_W   = 3;
  localparam int unsigned RPT_W  = 25;
  localparam int unsigned SYNC   = 2;
  localparam int          WIN    = 1 << DB_W;
  localparam int          HMAX   = 4096;

  logic clk;
  logic reset;

  debounce_repeat_bank_if #(.NUM_CH(NUM_CH), .RPT_W(RPT_W)) bus ();

  debounce_repeat_bank #(
    .NUM_CH      (NUM_CH),
    .DB_CNT_W    (DB_W),
    .RPT_W       (RPT_W),
    .SYNC_STAGES (SYNC),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: press accepted after WIN consecutive mismatching synchronised
  // samples; repeats fire when cycles since the last anchor reach the live target.
  logic [NUM_CH-1:0] st_m;
  logic [NUM_CH-1:0] down_m;
  logic [NUM_CH-1:0] up_m;
  logic [NUM_CH-1:0] rpt_m;
  int  run_m    [NUM_CH];
  int  anchor_m [NUM_CH];
  bit  first_m  [NUM_CH];
  bit  hist_m   [NUM_CH][HMAX];
  int  e_m      = 0;
  int  last_rst = 0;

  always @(posedge clk) begin
    e_m++;
    if (reset) begin
      last_rst = e_m;
      st_m   = '0;
      down_m = '0;
      up_m   = '0;
      rpt_m  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        run_m[c]    = 0;
        anchor_m[c] = e_m + 1;
        first_m[c]  = 1'b1;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit so;
        bit prev;
        int tgt;
        if (e_m < HMAX) hist_m[c][e_m] = ~bus.pb_in[c];
        so   = ((e_m - int'(SYNC)) > last_rst) ? hist_m[c][e_m - int'(SYNC)] : 1'b0;
        prev = st_m[c];
        if (so != st_m[c]) begin
          run_m[c]++;
          if (run_m[c] == WIN) begin
            st_m[c]  = ~st_m[c];
            run_m[c] = 0;
          end
        end else begin
          run_m[c] = 0;
        end
        down_m[c] = st_m[c] & ~prev;
        up_m[c]   = prev & ~st_m[c];
        rpt_m[c]  = 1'b0;
        if (st_m[c] && !prev) begin
          anchor_m[c] = e_m;
          first_m[c]  = 1'b1;
        end else if (prev && bus.rpt_en[c]) begin
          tgt = first_m[c] ? int'(bus.rpt_delay) : int'(bus.rpt_period);
          if (tgt != 0 && (e_m - anchor_m[c]) >= tgt) begin
            rpt_m[c]    = st_m[c];
            anchor_m[c] = e_m;
            first_m[c]  = 1'b0;
          end
        end else begin
          anchor_m[c] = e_m + 1;
          first_m[c]  = 1'b1;
        end
      end
    end
    #1;
    check("model_state", 32'(bus.pb_state), 32'(st_m));
    check("model_down",  32'(bus.pb_down),  32'(down_m));
    check("model_up",    32'(bus.pb_up),    32'(up_m));
    check("model_rpt",   32'(bus.pb_rpt),   32'(rpt_m));
    check("model_any",   32'(bus.pb_any),   32'(|st_m));
  end

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Press/release on a negedge, then land on the pb_state change edge.
  task automatic change_and_wait(input logic [NUM_CH-1:0] lvl);
    @(negedge clk);
    bus.pb_in = lvl;
    repeat (WIN + int'(SYNC) - 1) @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.pb_in      = 2'b11;
    bus.rpt_en     = 2'b00;
    bus.rpt_delay  = '0;
    bus.rpt_period = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle with buttons released.
    for (int k = 0; k < 50; k++) begin
      edge_sample();
      check("idle_outputs", 32'({bus.pb_state, bus.pb_down, bus.pb_up, bus.pb_rpt, bus.pb_any}), 32'd0);
    end

    // Clean press and release on ch0.
    change_and_wait(2'b10);
    check("press_edge9_state", 32'(bus.pb_state), 32'd0);
    edge_sample();
    check("press_edge10_state", 32'(bus.pb_state), 32'h1);
    check("press_edge10_down",  32'(bus.pb_down),  32'h1);
    check("press_edge10_any",   32'(bus.pb_any),   32'h1);
    edge_sample();
    check("press_down_width",   32'(bus.pb_down),  32'h0);
    idle(5);
    change_and_wait(2'b11);
    check("release_edge9_up",   32'(bus.pb_up),    32'h0);
    edge_sample();
    check("release_edge10_up",  32'(bus.pb_up),    32'h1);
    check("release_state",      32'(bus.pb_state), 32'h0);
    edge_sample();
    check("release_up_width",   32'(bus.pb_up),    32'h0);
    idle(5);

    // Glitch: seven low samples must be rejected.
    bus.pb_in = 2'b10;
    repeat (7) @(negedge clk);
    bus.pb_in = 2'b11;
    for (int k = 0; k < 15; k++) begin
      edge_sample();
      check("glitch_state", 32'({bus.pb_state, bus.pb_down}), 32'd0);
    end
    idle(2);

    // Auto-repeat delay 20, period 5; no repeat in the pb_up cycle.
    bus.rpt_en     = 2'b01;
    bus.rpt_delay  = 25'd20;
    bus.rpt_period = 25'd5;
    change_and_wait(2'b10);
    edge_sample();
    check("rpt_press_down", 32'(bus.pb_down), 32'h1);
    for (int k = 1; k <= 40; k++) begin
      edge_sample();
      check("rpt_d20_p5", 32'(bus.pb_rpt[0]), 32'((k >= 20) && ((k - 20) % 5 == 0)));
    end
    @(negedge clk);
    bus.pb_in = 2'b11;
    for (int k = 41; k <= 55; k++) begin
      edge_sample();
      check("rpt_release_rpt", 32'(bus.pb_rpt[0]), 32'(k == 45));
      check("rpt_release_up",  32'(bus.pb_up[0]),  32'(k == 50));
    end
    idle(3);

    // Period 0: a single repeat.
    bus.rpt_period = 25'd0;
    change_and_wait(2'b10);
    edge_sample();
    for (int k = 1; k <= 40; k++) begin
      edge_sample();
      check("rpt_period0", 32'(bus.pb_rpt[0]), 32'(k == 20));
    end
    change_and_wait(2'b11);
    idle(5);

    // Delay 0: no repeats.
    bus.rpt_delay  = 25'd0;
    bus.rpt_period = 25'd5;
    change_and_wait(2'b10);
    edge_sample();
    for (int k = 1; k <= 30; k++) begin
      edge_sample();
      check("rpt_delay0", 32'(bus.pb_rpt[0]), 32'd0);
    end
    change_and_wait(2'b11);
    idle(5);

    // Period lowered from 100 to 3 during cycle 50.
    bus.rpt_delay  = 25'd20;
    bus.rpt_period = 25'd100;
    change_and_wait(2'b10);
    edge_sample();
    for (int k = 1; k <= 60; k++) begin
      edge_sample();
      check("rpt_lowered", 32'(bus.pb_rpt[0]),
            32'(k == 20 || k == 51 || k == 54 || k == 57 || k == 60));
      if (k == 50) bus.rpt_period = 25'd3;
    end
    change_and_wait(2'b11);
    idle(5);

    // Both channels together; ch1 has repeat disabled.
    bus.rpt_delay  = 25'd4;
    bus.rpt_period = 25'd2;
    change_and_wait(2'b00);
    edge_sample();
    check("both_down", 32'(bus.pb_down), 32'h3);
    for (int k = 1; k <= 12; k++) begin
      edge_sample();
      check("both_rpt", 32'(bus.pb_rpt), 32'((k >= 4) && ((k - 4) % 2 == 0)));
    end
    change_and_wait(2'b11);
    edge_sample();
    check("both_up", 32'(bus.pb_up), 32'h3);
    idle(5);

    // Reset while ch0 is held: no pb_up, then a fresh pb_down.
    bus.rpt_en = 2'b00;
    change_and_wait(2'b10);
    edge_sample();
    check("pre_reset_state", 32'(bus.pb_state), 32'h1);
    idle(4);
    reset = 1'b1;
    #1;
    check("async_reset_state", 32'(bus.pb_state), 32'h0);
    check("async_reset_up",    32'(bus.pb_up),    32'h0);
    for (int k = 0; k < 2; k++) begin
      edge_sample();
      check("reset_no_up", 32'({bus.pb_up, bus.pb_any}), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (WIN + int'(SYNC) - 1) @(posedge clk);
    #1;
    check("post_reset_edge9_state", 32'(bus.pb_state), 32'h0);
    edge_sample();
    check("post_reset_down", 32'(bus.pb_down), 32'h1);
    change_and_wait(2'b11);
    idle(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
